uart_rx_axis_fifo: RTL and testbench
====================================

# uart_rx_axis_fifo

Receive end of the team's UART link: deserialises the asynchronous RX line into words and presents them on a back-pressured AXI-Stream master, buffered through an internal FIFO so a stalled consumer does not lose bytes. It pairs with the existing AXI-Stream-to-UART transmitter on the far end of a serial link. It also replaces the unbuffered receive path where the downstream sink needs tready flow control. Per-word parity and framing status travel in tuser alongside the data.

## Interface
- CLK_FREQ, 100: clock frequency in MHz
- BIT_RATE, 115200: line rate in bit/s
- BIT_PER_WORD, 8: data bits per word, 5..8
- PARITY_BIT, 0: 0 none, 1 odd, 2 even
- STOP_BITS_NUM, 1: 1 or 2
- FIFO_DEPTH, 16: words, power of two, ≥ 2
- aclk  in  1  single clock; all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- RX  in  1  UART line, idle high, asynchronous to aclk
- out_tdata  out  8  received word, LSB-aligned, upper bits zero when BIT_PER_WORD < 8
- out_tuser  out  2  bit0 parity error, bit1 framing error, for the word on out_tdata
- out_tvalid  out  1  FIFO not empty
- out_tready  in  1  consumer accepts word
- overrun  out  1  one-cycle pulse: completed word dropped, FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- BIT_DIV = round(CLK_FREQ·10⁶ / BIT_RATE); bit-phase counter runs 0..BIT_DIV-1. Require BIT_DIV ≥ 8.
- RX passes through a 2-flop synchroniser, both flops reset to 1. All decisions use the synchronised value rxs.
- States:
  - IDLE: on rxs 1→0, clear the phase counter and go to START.
  - START: at phase BIT_DIV/2, sample. If 1, it is a false start: go to IDLE. If 0, go to DATA.
  - DATA: sample BIT_DIV cycles after the previous sample, BIT_PER_WORD times, LSB first.
  - PARITY (only if PARITY_BIT≠0): one sample. Error when the ones-count of data plus parity bit is even for odd parity, or odd for even parity.
  - STOP: STOP_BITS_NUM samples. Any sampled 0 sets the framing error.
  - BREAK: entered after a framing error. Wait for rxs=1, then go to IDLE.
  - After the last stop sample with no framing error, go straight to IDLE in the same cycle so the next start edge is caught immediately.
- Push: at the last stop sample, write {status, data} into the FIFO. Framed-bad words are still pushed, with tuser[1]=1.
- FIFO:
  - Show-ahead. out_tdata and out_tuser always reflect the head entry.
  - Pop when out_tvalid && out_tready.
  - Push accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overrun pulses.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is updated +1, -1 or 0 for push/pop/both.

## Timing
- Reset (asynchronous assert, release sync to aclk):
  - state IDLE, counters 0, FIFO empty, synchroniser 11.
  - out_tvalid=0, out_tdata=0, out_tuser=0, overrun=0, fifo_count=0.
- Reset mid-frame: partial word discarded, nothing pushed.
- Push latency: out_tvalid rises 1 cycle after the last stop sample cycle, when the FIFO was empty.
- RX-to-sample latency: 2 synchroniser cycles plus BIT_DIV/2 from the line edge to the start sample.
- out_tvalid, once high, stays high with stable tdata/tuser until the handshake. The next head entry appears the cycle after the pop.
- overrun: asserted in the cycle after the dropped push, for exactly 1 cycle.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value is the majority of three rxs samples taken at phases BIT_DIV/2-1, BIT_DIV/2 and BIT_DIV/2+1. The start-bit check uses the same vote.
- UART_RX_MAJORITY_EN undefined: single sample at phase BIT_DIV/2.
- Timing of push and state transitions is identical in both builds: the decision is taken at phase BIT_DIV/2+1.

## Test plan
All scenarios use CLK_FREQ=100 and BIT_RATE=115200, so BIT_DIV=868.
- 8N1 byte 0xA5, out_tready=1:
  - out_tdata=0xA5, out_tuser=00.
  - out_tvalid high for 1 cycle, ~2+434+9·868 cycles after the start edge.
- Even parity, byte 0x03 sent with parity bit 1 -> out_tdata=0x03, out_tuser=01.
- 8N1 byte 0x55 with stop bit driven 0 for 2 bit times:
  - out_tuser=10.
  - A following 0x3C frame, sent after RX returns high, is received as 0x3C / 00.
- out_tready=0, send bytes 0x00..0x10 (17 words), FIFO_DEPTH=16:
  - fifo_count=16, overrun pulses once, on word 0x10.
  - Raising out_tready drains 0x00..0x0F in order; out_tvalid=0 afterwards.
- RX low pulse of 300 cycles then high -> no word pushed, state back in IDLE, fifo_count=0.
- areset asserted after 4 data bits of 0xF0, then released:
  - All outputs 0.
  - A fresh 0x96 frame is received as 0x96 / 00.
  - With UART_RX_MAJORITY_EN, a 1-cycle glitch at phase BIT_DIV/2 of a data bit does not change the received value.

Source files
------------

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver that deframes the RX line and buffers {status, data} words in a show-ahead
// FIFO drained over AXI-Stream. Define UART_RX_MAJORITY_EN to vote each bit over three mid-bit samples.
module uart_rx_axis_fifo #(
  parameter int CLK_FREQ      = 100,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          RX,
  output logic [7:0]                    out_tdata,
  output logic [1:0]                    out_tuser,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BIT_DIV = int'((longint'(CLK_FREQ) * 1000000 + BIT_RATE / 2) / BIT_RATE);
  localparam int HALF    = BIT_DIV / 2;
  localparam int PW      = $clog2(BIT_DIV);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;

  logic          sync0, rxs, rxs_d;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    data;
  logic          perr, ferr;
  logic          smp_mid, bit_v, dec, push;

  always_ff @(posedge aclk or posedge areset)
    if (areset) {sync0, rxs, rxs_d} <= 3'b111;
    else        {sync0, rxs, rxs_d} <= {RX, sync0, rxs};

`ifdef UART_RX_MAJORITY_EN
  logic smp_pre;
  always_ff @(posedge aclk or posedge areset)
    if (areset)                     smp_pre <= 1'b1;
    else if (phase == PW'(HALF - 1)) smp_pre <= rxs;
  assign bit_v = (smp_pre & smp_mid) | (smp_pre & rxs) | (smp_mid & rxs);
`else
  assign bit_v = smp_mid;
`endif

  // Decisions land one phase after mid-bit so both builds share the same timing.
  assign dec = (state != IDLE) && (state != BREAK) && (phase == PW'(HALF + 1));

  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE:    if (rxs_d && !rxs) state_n = START;
      START:   if (dec) state_n = bit_v ? IDLE : DATA;
      DATA:    if (dec && bit_cnt == 3'(BIT_PER_WORD - 1))
                 state_n = (PARITY_BIT != 0) ? PARITY : STOP;
      PARITY:  if (dec) state_n = STOP;
      STOP:    if (dec && bit_cnt == 3'(STOP_BITS_NUM - 1)) begin
                 push    = 1'b1;
                 state_n = (ferr || !bit_v) ? BREAK : IDLE;
               end
      BREAK:   if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      phase   <= '0;
      bit_cnt <= '0;
      data    <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      smp_mid <= 1'b1;
    end else begin
      if (state == IDLE || phase == PW'(BIT_DIV - 1)) phase <= '0;
      else                                            phase <= phase + 1'b1;
      if (phase == PW'(HALF)) smp_mid <= rxs;
      if (state_n != state) bit_cnt <= '0;
      else if (dec)         bit_cnt <= bit_cnt + 1'b1;
      if (state == START) begin
        data <= '0;
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (dec)
        case (state)
          DATA:    data[bit_cnt] <= bit_v;
          PARITY:  perr <= (PARITY_BIT == 1) ? ~(^data ^ bit_v) : (^data ^ bit_v);
          STOP:    if (!bit_v) ferr <= 1'b1;
          default: ;
        endcase
    end

  // Show-ahead FIFO: head entry is driven straight from the array.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, accept;

  assign out_tvalid = (fifo_count != '0);
  assign pop        = out_tvalid && out_tready;
  assign accept     = push && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
  assign {out_tuser, out_tdata} = mem[rd_ptr];

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {ferr | ~bit_v, perr, data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      overrun <= push && !accept;
    end
endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench: fast-rate 8N1 instance checked every cycle against a queue model of the receive
// FIFO; a spec-rate 8E1 instance checked with literal expectations.
module tb_uart_rx_axis_fifo;
  localparam int DF = 10;   // 100 MHz / 10 Mbit/s
  localparam int HF = DF / 2;
  localparam int DS = 868;  // 100 MHz / 115200
  localparam int HS = DS / 2;
  localparam int DEPTH = 16;

  logic aclk = 1'b0, areset, rx, rx_s, out_tready, rdy_s, rnd_rdy;
  logic [7:0] out_tdata, out_tdata_s;
  logic [1:0] out_tuser, out_tuser_s;
  logic out_tvalid, out_tvalid_s, overrun, overrun_s;
  logic [4:0] fifo_count, fifo_count_s;

  uart_rx_axis_fifo #(.CLK_FREQ(100), .BIT_RATE(10000000), .BIT_PER_WORD(8), .PARITY_BIT(0),
                      .STOP_BITS_NUM(1), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .RX(rx), .out_tdata(out_tdata), .out_tuser(out_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .overrun(overrun), .fifo_count(fifo_count));

  uart_rx_axis_fifo #(.CLK_FREQ(100), .BIT_RATE(115200), .BIT_PER_WORD(8), .PARITY_BIT(2),
                      .STOP_BITS_NUM(1), .FIFO_DEPTH(16)) dut_s (
    .aclk(aclk), .areset(areset), .RX(rx_s), .out_tdata(out_tdata_s), .out_tuser(out_tuser_s),
    .out_tvalid(out_tvalid_s), .out_tready(rdy_s), .overrun(overrun_s), .fifo_count(fifo_count_s));

  always #5 aclk = ~aclk;

  longint cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Expected pushes: the cycle whose edge writes the word, and {tuser, tdata}.
  typedef struct { longint e; logic [9:0] w; } ev_t;
  ev_t sched[$];
  logic [9:0] mq[$];
  logic ovr_exp = 1'b0;
  logic m_pop, m_push, m_full;
  ev_t m_ev;

  always @(negedge aclk) begin
    if (areset) begin
      mq.delete();
      sched.delete();
      ovr_exp = 1'b0;
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_tuser", out_tuser, 0);
    end else begin
      chk("m_tvalid", out_tvalid, mq.size() != 0);
      chk("m_count", fifo_count, mq.size());
      chk("m_overrun", overrun, ovr_exp);
      if (mq.size() != 0) chk("m_head", {out_tuser, out_tdata}, mq[0]);
      m_pop  = (mq.size() != 0) && out_tready;
      m_full = mq.size() >= DEPTH;
      m_push = (sched.size() != 0) && (sched[0].e == cyc + 1);
      if (m_pop) void'(mq.pop_front());
      ovr_exp = 1'b0;
      if (m_push) begin
        m_ev = sched.pop_front();
        if (!m_full || m_pop) mq.push_back(m_ev.w);
        else ovr_exp = 1'b1;
      end
    end
  end

  logic [9:0] got[$];
  ev_t sv[$];
  int ovr_cnt = 0;
  always @(negedge aclk) begin
    if (!areset && out_tvalid && out_tready) got.push_back({out_tuser, out_tdata});
    if (!areset && out_tvalid_s) sv.push_back('{e: cyc, w: {out_tuser_s, out_tdata_s}});
    if (overrun) ovr_cnt++;
  end

  // Hold a line level for n cycles; called just after a rising edge.
  task automatic hold(input bit s, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (s) rx_s = v; else rx = v;
      if (rnd_rdy) out_tready = ($urandom_range(0, 3) != 0);
      @(posedge aclk); #1;
    end
  endtask

  // g >= 0 inverts the line for one cycle at the mid-bit sample of data bit g.
  task automatic frame(input bit s, input logic [7:0] b, input int par, input int stop_lo, input int g);
    int d, h;
    d = s ? DS : DF;
    h = d / 2;
    hold(s, 1'b0, d);
    for (int i = 0; i < 8; i++)
      if (i == g) begin
        hold(s, b[i], h + 1); hold(s, ~b[i], 1); hold(s, b[i], d - h - 2);
      end else hold(s, b[i], d);
    if (par >= 0) hold(s, par[0], d);
    if (stop_lo > 0) hold(s, 1'b0, stop_lo * d);
    hold(s, 1'b1, d);
  endtask

  // Word is written at the edge ending the cycle one phase after mid-stop:
  // 2 sync + 1 edge detect + (HF+1) phases + 1 register, then 9 more bit times.
  task automatic fsend(input logic [7:0] b, input int stop_lo, input int g);
    ev_t ev;
    ev.e = cyc + HF + 5 + 9 * DF;
    ev.w = {stop_lo > 0, 1'b0, b};
    sched.push_back(ev);
    frame(0, b, -1, stop_lo, g);
  endtask

  int b0, gb, ob, glitch;
  longint k, lat;
  initial begin
    areset = 1'b1; rx = 1'b1; rx_s = 1'b1; out_tready = 1'b1; rdy_s = 1'b1; rnd_rdy = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    glitch = 2;
`else
    glitch = -1;
`endif
    repeat (5) begin @(posedge aclk); #1; end
    chk("rst_s_tvalid", out_tvalid_s, 0);
    chk("rst_s_count", fifo_count_s, 0);
    chk("rst_s_tdata", out_tdata_s, 0);
    areset = 1'b0;
    hold(0, 1'b1, 10);

    // Spec-rate 8E1: 0xA5 (four ones, parity 0), then 0x03 with a wrong parity bit 1.
    b0 = sv.size(); k = cyc;
    frame(1, 8'hA5, 0, 0, -1);
    hold(1, 1'b1, 20);
    chk("s_a5_valid_cycles", sv.size() - b0, 1);
    if (sv.size() > b0) begin
      chk("s_a5_word", sv[b0].w, 10'h0A5);
      lat = sv[b0].e - k;
      n_chk++;
      if (lat < 2 + HS + 10 * DS + 1 - 3 || lat > 2 + HS + 10 * DS + 1 + 3) begin
        n_fail++;
        $display("FAIL s_a5_latency: got %0d expected about %0d", lat, 2 + HS + 10 * DS + 1);
      end
    end
    b0 = sv.size();
    frame(1, 8'h03, 1, 0, -1);
    hold(1, 1'b1, 20);
    chk("s_03_valid_cycles", sv.size() - b0, 1);
    if (sv.size() > b0) chk("s_03_word", sv[b0].w, 10'h103);
    b0 = sv.size();
    hold(1, 1'b0, 300);
    hold(1, 1'b1, 1500);
    chk("s_false_words", sv.size() - b0, 0);
    chk("s_false_count", fifo_count_s, 0);

    // Fast instance: false start, framing error with break, overrun, random traffic.
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 30);
    chk("f_false_count", fifo_count, 0);

    gb = got.size();
    fsend(8'h55, 2, -1);
    hold(0, 1'b1, 5);
    fsend(8'h3C, 0, -1);
    hold(0, 1'b1, 20);
    chk("brk_words", got.size() - gb, 2);
    if (got.size() >= gb + 2) begin
      chk("brk_55", got[gb], 10'h255);
      chk("brk_3c", got[gb + 1], 10'h03C);
    end

    out_tready = 1'b0; ob = ovr_cnt;
    for (int i = 0; i <= 16; i++) begin
      fsend(8'(i), 0, -1);
      hold(0, 1'b1, 4);
    end
    hold(0, 1'b1, 10);
    chk("ovr_count_full", fifo_count, 16);
    chk("ovr_pulses", ovr_cnt - ob, 1);
    gb = got.size();
    out_tready = 1'b1;
    hold(0, 1'b1, 30);
    chk("drain_words", got.size() - gb, 16);
    if (got.size() >= gb + 16) begin
      chk("drain_first", got[gb], 10'h000);
      chk("drain_last", got[gb + 15], 10'h00F);
    end
    chk("drain_tvalid", out_tvalid, 0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      fsend(8'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0, -1);
      hold(0, 1'b1, $urandom_range(3, 15));
    end
    rnd_rdy = 1'b0; out_tready = 1'b1;
    hold(0, 1'b1, 40);
    chk("rand_drained", out_tvalid, 0);

    // Reset during a frame with a word already buffered.
    out_tready = 1'b0;
    fsend(8'h5A, 0, -1);
    hold(0, 1'b1, 5);
    hold(0, 1'b0, 5 * DF);
    areset = 1'b1; rx = 1'b1;
    #1;
    chk("mid_rst_tvalid", out_tvalid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_tdata", out_tdata, 0);
    hold(0, 1'b1, 3);
    areset = 1'b0; out_tready = 1'b1;
    hold(0, 1'b1, 5);
    gb = got.size();
    fsend(8'h96, 0, glitch);
    hold(0, 1'b1, 20);
    chk("post_rst_words", got.size() - gb, 1);
    if (got.size() > gb) chk("post_rst_96", got[gb], 10'h096);

    hold(0, 1'b1, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
